cache_refill_engine: RTL

- Line-refill master that sits directly downstream of the instruction-cache controller.
- On a miss it fetches all words of one cache line from main memory over a valid/ready word bus.
- Each returned word is presented to the cache data/tag RAMs as an indexed write with its block offset.
- Signals line completion so the controller returns to lookup.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_refill_engine.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing for the instruction-cache refill path.
package cache_pkg;

    localparam int CACHE_ADDR_WIDTH  = 32;
    localparam int CACHE_INDEX_WIDTH = 5;
    localparam int CACHE_BLOCK_WIDTH = 2;
    localparam int CACHE_TAG_WIDTH   = CACHE_ADDR_WIDTH - CACHE_INDEX_WIDTH - CACHE_BLOCK_WIDTH - 2;
    localparam int WORDS_PER_LINE    = 1 << CACHE_BLOCK_WIDTH;

    typedef logic [CACHE_INDEX_WIDTH-1:0] index_t;
    typedef logic [CACHE_BLOCK_WIDTH-1:0] block_t;
    typedef logic [CACHE_TAG_WIDTH-1:0]   tag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } refill_state_t;

endpackage

// File: rtl/cache_refill_engine.sv
// Line-refill master: fetches one cache line word by word and writes it into the cache RAMs.
// Define CACHE_REFILL_CWF_EN to start the line at the missing word (critical-word-first).
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int BLOCK_WIDTH = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic                   o_mem_rd,
    input  logic                   i_mem_ready,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata,
    input  logic                   i_mem_valid,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic [BLOCK_WIDTH-1:0] o_block,
    output logic [ADDR_WIDTH-INDEX_WIDTH-BLOCK_WIDTH-3:0] o_tag,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_wr
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_WIDTH - 2;
    localparam int IDX_LSB   = BLOCK_WIDTH + 2;
    localparam int TAG_LSB   = INDEX_WIDTH + BLOCK_WIDTH + 2;
    localparam logic [BLOCK_WIDTH-1:0] LAST_WORD = '1;

    refill_state_t          state, state_next;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [BLOCK_WIDTH-1:0] block_q;
    logic [BLOCK_WIDTH-1:0] count_q;
    logic [BLOCK_WIDTH-1:0] start_block;
    logic                   unused_addr_bits;

    // Byte-offset bits never matter; the word offset only matters with CWF.
    assign unused_addr_bits = ^i_addr[BLOCK_WIDTH+1:0];

`ifdef CACHE_REFILL_CWF_EN
    assign start_block = i_addr[BLOCK_WIDTH+1:2];
`else
    assign start_block = '0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state   <= IDLE;
            tag_q   <= '0;
            index_q <= '0;
            block_q <= '0;
            count_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        tag_q   <= i_addr[ADDR_WIDTH-1:TAG_LSB];
                        index_q <= i_addr[TAG_LSB-1:IDX_LSB];
                        block_q <= start_block;
                        count_q <= '0;
                    end
                end
                // Completion is tracked by count_q, so block_q may wrap freely under CWF.
                DATA: begin
                    if (i_mem_valid && (count_q != LAST_WORD)) begin
                        block_q <= block_q + 1'b1;
                        count_q <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        o_wr       = 1'b0;
        o_index    = '0;
        o_block    = '0;
        o_tag      = '0;
        o_data     = '0;
        // Outputs stay quiet while reset is held, even before the state register clears.
        if (i_reset) begin
            case (state)
                IDLE: begin
                    if (i_req) state_next = ADDR;
                end
                ADDR: begin
                    o_busy     = 1'b1;
                    o_mem_rd   = 1'b1;
                    o_mem_addr = {tag_q, index_q, block_q, 2'b00};
                    if (i_mem_ready) state_next = DATA;
                end
                DATA: begin
                    o_busy = 1'b1;
                    if (i_mem_valid) begin
                        o_wr       = 1'b1;
                        o_data     = i_mem_rdata;
                        o_index    = index_q;
                        o_block    = block_q;
                        o_tag      = tag_q;
                        state_next = (count_q == LAST_WORD) ? DONE : ADDR;
                    end
                end
                DONE: begin
                    o_busy     = 1'b1;
                    o_done     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
